// File: rtl/cci_mem_responder_if.sv
// Request/response bundle between an AFU requester and the memory-side responder.
// The master modport is the AFU side; the slave modport is the responder.
interface cci_mem_responder_if #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned MEM_LOG2    = 10
);
    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_en;
    logic                   rd_req_almostfull;
    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;
    logic [ADDR_LMT-1:0]    wr_req_addr;
    logic [MDATA-1:0]       wr_req_mdata;
    logic [CACHE_WIDTH-1:0] wr_req_data;
    logic                   wr_req_en;
    logic                   wr_req_almostfull;
    logic                   wr_rsp0_valid;
    logic [MDATA-1:0]       wr_rsp0_mdata;
    logic                   wr_rsp1_valid;
    logic [MDATA-1:0]       wr_rsp1_mdata;
    logic                   init_we;
    logic [MEM_LOG2-1:0]    init_addr;
    logic [CACHE_WIDTH-1:0] init_data;
    logic                   err_overflow;

    modport master (
        output rd_req_addr, rd_req_mdata, rd_req_en,
        output wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
        output init_we, init_addr, init_data,
        input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        input  wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        input  err_overflow
    );

    modport slave (
        input  rd_req_addr, rd_req_mdata, rd_req_en,
        input  wr_req_addr, wr_req_mdata, wr_req_data, wr_req_en,
        input  init_we, init_addr, init_data,
        output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        output wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        output err_overflow
    );
endinterface

// File: rtl/cci_mem_responder.sv
// Memory-side responder: queues AFU read/write requests and services them from a
// preloadable line memory, with fixed-latency reads and alternating write completions.
module cci_mem_responder #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned MEM_LOG2    = 10,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned AF_SLACK    = 2,
    parameter int unsigned RD_LAT      = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    cci_mem_responder_if.slave  bus
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned Lines = 2 ** MEM_LOG2;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntAf   = CntW'(FIFO_DEPTH - AF_SLACK);

    logic [CACHE_WIDTH-1:0] r_mem [Lines];

    // Read queue
    logic [MEM_LOG2-1:0] r_rq_idx [FIFO_DEPTH];
    logic [MDATA-1:0]    r_rq_md  [FIFO_DEPTH];
    logic [PtrW-1:0]     r_rq_wp, r_rq_rp;
    logic [CntW-1:0]     r_rq_cnt;
    logic                w_rq_full, w_rq_push, w_rq_pop;
    logic [CntW-1:0]     w_rq_cnt_d;

    // Write queue
    logic [MEM_LOG2-1:0]    r_wq_idx  [FIFO_DEPTH];
    logic [MDATA-1:0]       r_wq_md   [FIFO_DEPTH];
    logic [CACHE_WIDTH-1:0] r_wq_data [FIFO_DEPTH];
    logic [PtrW-1:0]        r_wq_wp, r_wq_rp;
    logic [CntW-1:0]        r_wq_cnt;
    logic                   w_wq_full, w_wq_push, w_wq_pop;
    logic [CntW-1:0]        w_wq_cnt_d;

    logic r_rd_af, r_wr_af, r_err;

    // Read lookup stage and response pipeline
    logic                   r_lk_vld;
    logic [MEM_LOG2-1:0]    r_lk_idx;
    logic [MDATA-1:0]       r_lk_md;
    logic [CACHE_WIDTH-1:0] w_lk_data;
    logic                   r_pv   [RD_LAT];
    logic [MDATA-1:0]       r_pmd  [RD_LAT];
    logic [CACHE_WIDTH-1:0] r_pdat [RD_LAT];

    // Write completions
    logic             r_wpar;
    logic             r_wc0_vld, r_wc1_vld;
    logic [MDATA-1:0] r_wc0_md, r_wc1_md;

    logic w_unused;
    assign w_unused = ^{bus.rd_req_addr[ADDR_LMT-1:MEM_LOG2], bus.wr_req_addr[ADDR_LMT-1:MEM_LOG2]};

    // Fullness is judged on the pre-pop count, so a push to a full queue drops.
    always_comb begin
        w_rq_full  = (r_rq_cnt == CntFull);
        w_rq_push  = bus.rd_req_en && !w_rq_full;
        w_rq_pop   = (r_rq_cnt != '0) && !bus.init_we;
        w_rq_cnt_d = r_rq_cnt + CntW'(w_rq_push) - CntW'(w_rq_pop);
        w_wq_full  = (r_wq_cnt == CntFull);
        w_wq_push  = bus.wr_req_en && !w_wq_full;
        w_wq_pop   = (r_wq_cnt != '0) && !bus.init_we;
        w_wq_cnt_d = r_wq_cnt + CntW'(w_wq_push) - CntW'(w_wq_pop);
        // A write popped on the same edge as the read lookup has already landed in r_mem.
        w_lk_data  = r_lk_vld ? r_mem[r_lk_idx] : '0;
    end

    // Queue storage and line memory carry no reset so preloaded contents survive.
    always_ff @(posedge clk) begin
        if (w_rq_push) begin
            r_rq_idx[r_rq_wp] <= bus.rd_req_addr[MEM_LOG2-1:0];
            r_rq_md[r_rq_wp]  <= bus.rd_req_mdata;
        end
        if (w_wq_push) begin
            r_wq_idx[r_wq_wp]  <= bus.wr_req_addr[MEM_LOG2-1:0];
            r_wq_md[r_wq_wp]   <= bus.wr_req_mdata;
            r_wq_data[r_wq_wp] <= bus.wr_req_data;
        end
        if (bus.init_we) begin
            r_mem[bus.init_addr] <= bus.init_data;
        end else if (w_wq_pop) begin
            r_mem[r_wq_idx[r_wq_rp]] <= r_wq_data[r_wq_rp];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rq_wp   <= '0;
            r_rq_rp   <= '0;
            r_rq_cnt  <= '0;
            r_wq_wp   <= '0;
            r_wq_rp   <= '0;
            r_wq_cnt  <= '0;
            r_rd_af   <= 1'b0;
            r_wr_af   <= 1'b0;
            r_err     <= 1'b0;
            r_lk_vld  <= 1'b0;
            r_lk_idx  <= '0;
            r_lk_md   <= '0;
            r_wpar    <= 1'b0;
            r_wc0_vld <= 1'b0;
            r_wc0_md  <= '0;
            r_wc1_vld <= 1'b0;
            r_wc1_md  <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pv[i]   <= 1'b0;
                r_pmd[i]  <= '0;
                r_pdat[i] <= '0;
            end
        end else begin
            if (w_rq_push) r_rq_wp <= r_rq_wp + PtrW'(1);
            if (w_rq_pop)  r_rq_rp <= r_rq_rp + PtrW'(1);
            if (w_wq_push) r_wq_wp <= r_wq_wp + PtrW'(1);
            if (w_wq_pop)  r_wq_rp <= r_wq_rp + PtrW'(1);
            r_rq_cnt <= w_rq_cnt_d;
            r_wq_cnt <= w_wq_cnt_d;
            r_rd_af  <= (w_rq_cnt_d >= CntAf);
            r_wr_af  <= (w_wq_cnt_d >= CntAf);
            r_err    <= r_err | (bus.rd_req_en && w_rq_full) | (bus.wr_req_en && w_wq_full);

            r_lk_vld <= w_rq_pop;
            if (w_rq_pop) begin
                r_lk_idx <= r_rq_idx[r_rq_rp];
                r_lk_md  <= r_rq_md[r_rq_rp];
            end
            r_pv[0]   <= r_lk_vld;
            r_pmd[0]  <= r_lk_vld ? r_lk_md : '0;
            r_pdat[0] <= w_lk_data;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pmd[i]  <= r_pmd[i-1];
                r_pdat[i] <= r_pdat[i-1];
            end

            r_wc0_vld <= w_wq_pop && !r_wpar;
            r_wc0_md  <= (w_wq_pop && !r_wpar) ? r_wq_md[r_wq_rp] : '0;
            r_wc1_vld <= w_wq_pop && r_wpar;
            r_wc1_md  <= (w_wq_pop && r_wpar) ? r_wq_md[r_wq_rp] : '0;
            if (w_wq_pop) r_wpar <= ~r_wpar;
        end
    end

    assign bus.rd_req_almostfull = r_rd_af;
    assign bus.wr_req_almostfull = r_wr_af;
    assign bus.err_overflow      = r_err;
    assign bus.rd_rsp_valid      = r_pv[RD_LAT-1];
    assign bus.rd_rsp_mdata      = r_pmd[RD_LAT-1];
    assign bus.rd_rsp_data       = r_pdat[RD_LAT-1];
    assign bus.wr_rsp0_valid     = r_wc0_vld;
    assign bus.wr_rsp0_mdata     = r_wc0_md;
    assign bus.wr_rsp1_valid     = r_wc1_vld;
    assign bus.wr_rsp1_mdata     = r_wc1_md;
endmodule

// File: tb/tb_cci_mem_responder.sv
// Directed bench for cci_mem_responder: latency, write-completion alternation,
// overflow, write-first ordering, reset in flight and back-to-back throughput.
module tb_cci_mem_responder;
    localparam int unsigned ADDR_LMT    = 20;
    localparam int unsigned MDATA       = 14;
    localparam int unsigned CACHE_WIDTH = 512;
    localparam int unsigned MEM_LOG2    = 10;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned AF_SLACK    = 2;
    localparam int unsigned RD_LAT      = 4;
    localparam longint      PERIOD      = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cci_mem_responder_if #(
        .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CACHE_WIDTH), .MEM_LOG2(MEM_LOG2)
    ) bus ();

    cci_mem_responder #(
        .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CACHE_WIDTH), .MEM_LOG2(MEM_LOG2),
        .FIFO_DEPTH(FIFO_DEPTH), .AF_SLACK(AF_SLACK), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;
    int junk_cnt = 0;

    logic [MDATA-1:0]       rd_md_q  [$];
    logic [CACHE_WIDTH-1:0] rd_dat_q [$];
    longint                 rd_t_q   [$];
    logic                   wr_ch_q  [$];
    logic [MDATA-1:0]       wr_md_q  [$];
    longint                 wr_t_q   [$];

    logic [CACHE_WIDTH-1:0] pat_a5;

    // Records every response 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.rd_rsp_valid) begin
            rd_md_q.push_back(bus.rd_rsp_mdata);
            rd_dat_q.push_back(bus.rd_rsp_data);
            rd_t_q.push_back(longint'($time));
        end else if (bus.rd_rsp_data !== '0) begin
            junk_cnt++;
        end
        if (bus.wr_rsp0_valid && bus.wr_rsp1_valid) both_cnt++;
        if (bus.wr_rsp0_valid) begin
            wr_ch_q.push_back(1'b0);
            wr_md_q.push_back(bus.wr_rsp0_mdata);
            wr_t_q.push_back(longint'($time));
        end
        if (bus.wr_rsp1_valid) begin
            wr_ch_q.push_back(1'b1);
            wr_md_q.push_back(bus.wr_rsp1_mdata);
            wr_t_q.push_back(longint'($time));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    function automatic logic [559:0] all_outs();
        return {bus.rd_rsp_valid, bus.rd_rsp_mdata, bus.rd_rsp_data, bus.rd_req_almostfull,
                bus.wr_req_almostfull, bus.wr_rsp0_valid, bus.wr_rsp0_mdata,
                bus.wr_rsp1_valid, bus.wr_rsp1_mdata, bus.err_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.rd_req_en    = 1'b0;
        bus.rd_req_addr  = '0;
        bus.rd_req_mdata = '0;
        bus.wr_req_en    = 1'b0;
        bus.wr_req_addr  = '0;
        bus.wr_req_mdata = '0;
        bus.wr_req_data  = '0;
        bus.init_we      = 1'b0;
        bus.init_addr    = '0;
        bus.init_data    = '0;
    endtask

    task automatic clear_q();
        rd_md_q.delete();
        rd_dat_q.delete();
        rd_t_q.delete();
        wr_ch_q.delete();
        wr_md_q.delete();
        wr_t_q.delete();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (all_outs() !== '0) begin
            $display("FAIL reset_outs: got %h required 0", all_outs());
            errors++;
        end
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_outs() !== '0) begin
            $display("FAIL idle_outs: got %h required 0", all_outs());
            errors++;
        end
    endtask

    task automatic test_read_latency();
        longint t0;
        int n;
        bus.init_we   = 1'b1;
        bus.init_addr = 10'd3;
        bus.init_data = pat_a5;
        tick();
        idle();
        clear_q();
        bus.rd_req_en    = 1'b1;
        bus.rd_req_addr  = 20'd3;
        bus.rd_req_mdata = 14'h15;
        t0 = longint'($time) - 1;
        tick();
        idle();
        n = 0;
        while (rd_md_q.size() == 0 && n < 30) begin
            tick();
            n++;
        end
        repeat (5) tick();
        checks++;
        if (rd_md_q.size() != 1) begin
            $display("FAIL rd_single_count: got %0d responses required 1", rd_md_q.size());
            errors++;
        end
        if (rd_md_q.size() >= 1) begin
            checks++;
            if (rd_t_q[0] - t0 != longint'(RD_LAT + 2) * PERIOD) begin
                $display("FAIL rd_latency: got %0d cycles required %0d",
                         (rd_t_q[0] - t0) / PERIOD, RD_LAT + 2);
                errors++;
            end
            checks++;
            if (rd_md_q[0] !== 14'h15) begin
                $display("FAIL rd_mdata: got %h required 15", rd_md_q[0]);
                errors++;
            end
            checks++;
            if (rd_dat_q[0] !== pat_a5) begin
                $display("FAIL rd_data_a5: got %h required %h", rd_dat_q[0], pat_a5);
                errors++;
            end
        end
    endtask

    task automatic test_write_alternate();
        logic [CACHE_WIDTH-1:0] exp;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bus.wr_req_en    = 1'b1;
            bus.wr_req_addr  = ADDR_LMT'(i);
            bus.wr_req_mdata = MDATA'(i + 1);
            bus.wr_req_data  = CACHE_WIDTH'(32'h100 + i);
            tick();
        end
        idle();
        repeat (6) tick();
        checks++;
        if (wr_md_q.size() != 4) begin
            $display("FAIL wr_count: got %0d completions required 4", wr_md_q.size());
            errors++;
        end
        for (int i = 0; i < wr_md_q.size() && i < 4; i++) begin
            checks++;
            if (wr_ch_q[i] !== i[0] || wr_md_q[i] !== MDATA'(i + 1)) begin
                $display("FAIL wr_alt[%0d]: got ch%0d mdata %h required ch%0d mdata %h",
                         i, wr_ch_q[i], wr_md_q[i], i[0], i + 1);
                errors++;
            end
            if (i > 0) begin
                checks++;
                if (wr_t_q[i] - wr_t_q[i-1] != PERIOD) begin
                    $display("FAIL wr_gap[%0d]: got %0d required %0d",
                             i, wr_t_q[i] - wr_t_q[i-1], PERIOD);
                    errors++;
                end
            end
        end
        clear_q();
        for (int i = 0; i < 4; i++) begin
            bus.rd_req_en    = 1'b1;
            bus.rd_req_addr  = ADDR_LMT'(i);
            bus.rd_req_mdata = MDATA'(32'h20 + i);
            tick();
        end
        idle();
        repeat (RD_LAT + 8) tick();
        checks++;
        if (rd_md_q.size() != 4) begin
            $display("FAIL rd_after_wr_count: got %0d required 4", rd_md_q.size());
            errors++;
        end
        for (int i = 0; i < rd_md_q.size() && i < 4; i++) begin
            exp = CACHE_WIDTH'(32'h100 + i);
            checks++;
            if (rd_dat_q[i] !== exp || rd_md_q[i] !== MDATA'(32'h20 + i)) begin
                $display("FAIL rd_after_wr[%0d]: got mdata %h data %h required mdata %h data %h",
                         i, rd_md_q[i], rd_dat_q[i][31:0], 32'h20 + i, exp[31:0]);
                errors++;
            end
        end
    endtask

    task automatic test_overflow();
        clear_q();
        bus.init_we   = 1'b1;
        bus.init_addr = 10'd3;
        bus.init_data = pat_a5;
        tick();
        for (int k = 1; k <= 8; k++) begin
            bus.rd_req_en    = 1'b1;
            bus.rd_req_addr  = 20'd3;
            bus.rd_req_mdata = MDATA'(32'h30 + k - 1);
            tick();
            checks++;
            if (bus.rd_req_almostfull !== (k >= 6)) begin
                $display("FAIL rd_af[occ %0d]: got %b required %b",
                         k, bus.rd_req_almostfull, k >= 6);
                errors++;
            end
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            $display("FAIL ovf_early: got %b required 0", bus.err_overflow);
            errors++;
        end
        bus.rd_req_mdata = 14'h3F;
        tick();
        bus.rd_req_en = 1'b0;
        checks++;
        if (bus.err_overflow !== 1'b1) begin
            $display("FAIL ovf_set: got %b required 1", bus.err_overflow);
            errors++;
        end
        checks++;
        if (rd_md_q.size() != 0) begin
            $display("FAIL stall_no_rsp: got %0d responses required 0", rd_md_q.size());
            errors++;
        end
        idle();
        repeat (8 + RD_LAT + 6) tick();
        checks++;
        if (rd_md_q.size() != 8) begin
            $display("FAIL ovf_drain_count: got %0d required 8", rd_md_q.size());
            errors++;
        end
        for (int i = 0; i < rd_md_q.size() && i < 8; i++) begin
            checks++;
            if (rd_md_q[i] !== MDATA'(32'h30 + i) || rd_dat_q[i] !== pat_a5) begin
                $display("FAIL ovf_drain[%0d]: got mdata %h required %h", i, rd_md_q[i], 32'h30 + i);
                errors++;
            end
        end
        checks++;
        if (bus.rd_req_almostfull !== 1'b0 || bus.err_overflow !== 1'b1) begin
            $display("FAIL ovf_after_drain: got af %b err %b required af 0 err 1",
                     bus.rd_req_almostfull, bus.err_overflow);
            errors++;
        end
    endtask

    task automatic test_write_first();
        bus.init_we   = 1'b1;
        bus.init_addr = 10'd7;
        bus.init_data = '0;
        tick();
        idle();
        clear_q();
        bus.rd_req_en    = 1'b1;
        bus.rd_req_addr  = 20'd7;
        bus.rd_req_mdata = 14'h11;
        bus.wr_req_en    = 1'b1;
        bus.wr_req_addr  = 20'd7;
        bus.wr_req_mdata = 14'h12;
        bus.wr_req_data  = CACHE_WIDTH'(8'hFF);
        tick();
        idle();
        repeat (RD_LAT + 6) tick();
        checks++;
        if (rd_md_q.size() != 1 || rd_dat_q[0] !== CACHE_WIDTH'(8'hFF)) begin
            $display("FAIL write_first: got %0d rsp data %h required 1 rsp data ff",
                     rd_md_q.size(), rd_dat_q.size() > 0 ? rd_dat_q[0][31:0] : 32'hx);
            errors++;
        end
        checks++;
        if (wr_ch_q.size() != 1 || wr_ch_q[0] !== 1'b0 || wr_md_q[0] !== 14'h12) begin
            $display("FAIL wr_fifth_ch: got %0d completions required 1 on ch0 mdata 12",
                     wr_ch_q.size());
            errors++;
        end
        clear_q();
        bus.rd_req_en    = 1'b1;
        bus.rd_req_addr  = 20'h407;
        bus.rd_req_mdata = 14'h13;
        tick();
        idle();
        repeat (RD_LAT + 6) tick();
        checks++;
        if (rd_md_q.size() != 1 || rd_md_q[0] !== 14'h13 || rd_dat_q[0] !== CACHE_WIDTH'(8'hFF)) begin
            $display("FAIL addr_wrap: got %0d rsp data %h required 1 rsp mdata 13 data ff",
                     rd_md_q.size(), rd_dat_q.size() > 0 ? rd_dat_q[0][31:0] : 32'hx);
            errors++;
        end
    endtask

    task automatic test_reset_in_flight();
        clear_q();
        bus.rd_req_en = 1'b1; bus.rd_req_addr = 20'd3; bus.rd_req_mdata = 14'h60;
        bus.wr_req_en = 1'b1; bus.wr_req_addr = 20'd10; bus.wr_req_mdata = 14'h70;
        bus.wr_req_data = CACHE_WIDTH'(1);
        tick();
        bus.rd_req_mdata = 14'h61;
        bus.wr_req_addr = 20'd11; bus.wr_req_mdata = 14'h71;
        tick();
        bus.rd_req_mdata = 14'h62;
        bus.wr_req_en = 1'b0;
        tick();
        idle();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            $display("FAIL async_reset_outs: got %h required 0", all_outs());
            errors++;
        end
        clear_q();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (RD_LAT + 10) tick();
        checks++;
        if (rd_md_q.size() != 0 || wr_md_q.size() != 0) begin
            $display("FAIL flushed: got %0d rd %0d wr responses required 0 0",
                     rd_md_q.size(), wr_md_q.size());
            errors++;
        end
        checks++;
        if (all_outs() !== '0) begin
            $display("FAIL post_reset_outs: got %h required 0", all_outs());
            errors++;
        end
        bus.rd_req_en = 1'b1; bus.rd_req_addr = 20'd3; bus.rd_req_mdata = 14'h66;
        tick();
        bus.rd_req_en = 1'b0;
        bus.wr_req_en = 1'b1; bus.wr_req_addr = 20'd12; bus.wr_req_mdata = 14'h67;
        tick();
        idle();
        repeat (RD_LAT + 6) tick();
        checks++;
        if (rd_md_q.size() != 1 || rd_md_q[0] !== 14'h66 || rd_dat_q[0] !== pat_a5) begin
            $display("FAIL mem_kept: got %0d rsp required 1 rsp mdata 66 data a5", rd_md_q.size());
            errors++;
        end
        checks++;
        if (wr_ch_q.size() != 1 || wr_ch_q[0] !== 1'b0 || wr_md_q[0] !== 14'h67) begin
            $display("FAIL parity_reset: got %0d completions required 1 on ch0 mdata 67",
                     wr_ch_q.size());
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [CACHE_WIDTH-1:0] exp;
        clear_q();
        for (int i = 0; i < 16; i++) begin
            bus.rd_req_en    = 1'b1;
            bus.rd_req_addr  = ADDR_LMT'(i % 3);
            bus.rd_req_mdata = MDATA'(32'h40 + i);
            tick();
        end
        idle();
        repeat (RD_LAT + 6) tick();
        checks++;
        if (rd_md_q.size() != 16) begin
            $display("FAIL b2b_count: got %0d required 16", rd_md_q.size());
            errors++;
        end
        for (int i = 0; i < rd_md_q.size() && i < 16; i++) begin
            exp = CACHE_WIDTH'(32'h100 + (i % 3));
            checks++;
            if (rd_md_q[i] !== MDATA'(32'h40 + i) || rd_dat_q[i] !== exp) begin
                $display("FAIL b2b[%0d]: got mdata %h data %h required mdata %h data %h",
                         i, rd_md_q[i], rd_dat_q[i][31:0], 32'h40 + i, exp[31:0]);
                errors++;
            end
            if (i > 0) begin
                checks++;
                if (rd_t_q[i] - rd_t_q[i-1] != PERIOD) begin
                    $display("FAIL b2b_gap[%0d]: got %0d required %0d",
                             i, rd_t_q[i] - rd_t_q[i-1], PERIOD);
                    errors++;
                end
            end
        end
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            $display("FAIL b2b_no_ovf: got %b required 0", bus.err_overflow);
            errors++;
        end
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        test_reset();
        test_read_latency();
        test_write_alternate();
        test_overflow();
        test_write_first();
        test_reset_in_flight();
        test_back_to_back();
        checks++;
        if (both_cnt != 0) begin
            $display("FAIL wr_both_valid: got %0d cycles required 0", both_cnt);
            errors++;
        end
        checks++;
        if (junk_cnt != 0) begin
            $display("FAIL rd_data_idle_zero: got %0d nonzero cycles required 0", junk_cnt);
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
